// File: rtl/awb_gain_sched_if.sv
// Purpose: control and gain bus between the AWB gain scheduler and its environment.
//   slave  : scheduler side (takes cfg_*, frame_end, cal_* in; drives cal_sel/cal_direct,
//            committed gains and status out)
//   master : environment side (mirror of slave)
interface awb_gain_sched_if #(
  parameter int unsigned GAIN_W = 8
);
  logic [1:0]        cfg_mode;
  logic              cfg_start;
  logic [GAIN_W-1:0] cfg_r_gain;
  logic [GAIN_W-1:0] cfg_g_gain;
  logic [GAIN_W-1:0] cfg_b_gain;
  logic              frame_end;
  logic              cal_valid;
  logic [GAIN_W-1:0] cal_r_gain;
  logic [GAIN_W-1:0] cal_g_gain;
  logic [GAIN_W-1:0] cal_b_gain;
  logic              cal_sel;
  logic              cal_direct;
  logic [GAIN_W-1:0] r_gain_out;
  logic [GAIN_W-1:0] g_gain_out;
  logic [GAIN_W-1:0] b_gain_out;
  logic              gain_update;
  logic              busy;
  logic              done;
  logic              tmo_err;

  modport master (
    output cfg_mode, cfg_start, cfg_r_gain, cfg_g_gain, cfg_b_gain,
           frame_end, cal_valid, cal_r_gain, cal_g_gain, cal_b_gain,
    input  cal_sel, cal_direct, r_gain_out, g_gain_out, b_gain_out,
           gain_update, busy, done, tmo_err
  );

  modport slave (
    input  cfg_mode, cfg_start, cfg_r_gain, cfg_g_gain, cfg_b_gain,
           frame_end, cal_valid, cal_r_gain, cal_g_gain, cal_b_gain,
    output cal_sel, cal_direct, r_gain_out, g_gain_out, b_gain_out,
           gain_update, busy, done, tmo_err
  );
endinterface

// File: rtl/awb_gain_sched.sv
// Purpose: frame-synchronous AWB gain scheduler. Sequences the gain calculator through
//   bypass / manual / auto-continuous / auto-one-shot, captures calculated gains and
//   commits slew-limited r/g/b gains only on frame_end so a frame never mixes gain sets.
// Ports:
//   clk   : pixel clock
//   rst_n : async active-low reset
//   bus   : awb_gain_sched_if.slave (config, frame_end, calculator handshake, gains, status)
module awb_gain_sched #(
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned UNITY      = 128,
  parameter int unsigned FRAME_SKIP = 2,
  parameter int unsigned STEP_MAX   = 8,
  parameter int unsigned TMO_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  awb_gain_sched_if.slave   bus
);

  localparam int unsigned SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam int unsigned TMO_W  = (TMO_FRAMES > 1) ? $clog2(TMO_FRAMES + 1) : 1;
  localparam logic [GAIN_W-1:0]   UNITY_G = GAIN_W'(UNITY);
  localparam logic signed [GAIN_W:0] STEP_P = (GAIN_W+1)'(STEP_MAX);
  localparam logic signed [GAIN_W:0] STEP_N = -STEP_P;

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_MEAS, S_APPLY} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_mode;
  logic [SKIP_W-1:0]   r_skip_cnt, w_skip_nxt;
  logic [TMO_W-1:0]    r_tmo_cnt, w_tmo_nxt;
  logic                r_armed, w_armed_nxt;
  logic [GAIN_W-1:0]   r_tgt_r, r_tgt_g, r_tgt_b;
  logic [GAIN_W-1:0]   r_gain_r, r_gain_g, r_gain_b;
  logic                r_cal_sel, r_cal_direct, r_gain_update, r_busy, r_done, r_tmo_err;

  logic                w_mode_chg, w_commit, w_latch, w_tmo_set, w_done_set, w_done_clr;
  logic [GAIN_W-1:0]   w_src_r, w_src_g, w_src_b;
  logic [GAIN_W-1:0]   w_new_r, w_new_g, w_new_b;
  logic                w_changed, w_hit_tgt;

  // One slew-limited, saturated commit step toward tgt.
  function automatic logic [GAIN_W-1:0] slew(input logic [GAIN_W-1:0] cur,
                                             input logic [GAIN_W-1:0] tgt);
    logic signed [GAIN_W:0]   d;
    logic signed [GAIN_W+1:0] sum;
    logic [GAIN_W-1:0]        res;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_P)      d = STEP_P;
    else if (d < STEP_N) d = STEP_N;
    sum = $signed({2'b00, cur}) + $signed({d[GAIN_W], d});
    if (sum[GAIN_W+1])    res = '0;
    else if (sum[GAIN_W]) res = '1;
    else                  res = sum[GAIN_W-1:0];
    return res;
  endfunction

  // A mode change is only recognised on frame_end, where cfg_mode is sampled.
  assign w_mode_chg = bus.frame_end && (bus.cfg_mode != r_mode);

  // Commit source: latched calculator result in APPLY, else bypass/manual target.
  assign w_src_r = (r_state == S_APPLY) ? r_tgt_r : (r_mode == 2'b01 ? bus.cfg_r_gain : UNITY_G);
  assign w_src_g = (r_state == S_APPLY) ? r_tgt_g : (r_mode == 2'b01 ? bus.cfg_g_gain : UNITY_G);
  assign w_src_b = (r_state == S_APPLY) ? r_tgt_b : (r_mode == 2'b01 ? bus.cfg_b_gain : UNITY_G);

  assign w_new_r   = slew(r_gain_r, w_src_r);
  assign w_new_g   = slew(r_gain_g, w_src_g);
  assign w_new_b   = slew(r_gain_b, w_src_b);
  assign w_changed = (w_new_r != r_gain_r) || (w_new_g != r_gain_g) || (w_new_b != r_gain_b);
  assign w_hit_tgt = (w_new_r == r_tgt_r) && (w_new_g == r_tgt_g) && (w_new_b == r_tgt_b);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_armed_nxt = r_armed;
    w_commit    = 1'b0;
    w_latch     = 1'b0;
    w_tmo_set   = 1'b0;
    w_done_set  = 1'b0;
    w_done_clr  = 1'b0;
    if (w_mode_chg) begin
      w_state_nxt = S_IDLE;
      w_skip_nxt  = '0;
      w_tmo_nxt   = '0;
      w_armed_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_mode[1]) begin
            w_commit = bus.frame_end;
          end else if (r_mode == 2'b10) begin
            if (bus.frame_end) begin
              w_state_nxt = S_SKIP;
              w_skip_nxt  = '0;
            end
          end else begin
            if (bus.cfg_start) begin
              w_armed_nxt = 1'b1;
              w_done_clr  = 1'b1;
            end
            if (bus.frame_end && r_armed) begin
              w_state_nxt = S_SKIP;
              w_skip_nxt  = '0;
              w_armed_nxt = 1'b0;
            end
          end
        end
        S_SKIP: begin
          if (bus.frame_end) begin
            if (r_skip_cnt == SKIP_W'(FRAME_SKIP - 1)) begin
              w_state_nxt = S_MEAS;
              w_skip_nxt  = '0;
              w_tmo_nxt   = '0;
            end else begin
              w_skip_nxt = r_skip_cnt + SKIP_W'(1);
            end
          end
        end
        S_MEAS: begin
          // A result arriving on the frame_end cycle beats the timeout count.
          if (bus.cal_valid) begin
            w_latch     = 1'b1;
            w_state_nxt = S_APPLY;
          end else if (bus.frame_end) begin
            if (r_tmo_cnt == TMO_W'(TMO_FRAMES - 1)) begin
              w_tmo_set   = 1'b1;
              w_tmo_nxt   = '0;
              w_skip_nxt  = '0;
              w_state_nxt = (r_mode == 2'b11) ? S_IDLE : S_SKIP;
            end else begin
              w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
            end
          end
        end
        S_APPLY: begin
          if (bus.frame_end) begin
            w_commit   = 1'b1;
            w_skip_nxt = '0;
            if (r_mode == 2'b11 && w_hit_tgt) begin
              w_done_set  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_SKIP;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= 2'b00;
      r_skip_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_armed       <= 1'b0;
      r_tgt_r       <= UNITY_G;
      r_tgt_g       <= UNITY_G;
      r_tgt_b       <= UNITY_G;
      r_gain_r      <= UNITY_G;
      r_gain_g      <= UNITY_G;
      r_gain_b      <= UNITY_G;
      r_cal_sel     <= 1'b0;
      r_cal_direct  <= 1'b1;
      r_gain_update <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tmo_err     <= 1'b0;
    end else begin
      if (bus.frame_end) r_mode <= bus.cfg_mode;
      r_skip_cnt <= w_skip_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_armed    <= w_armed_nxt;
      if (w_latch) begin
        r_tgt_r <= bus.cal_r_gain;
        r_tgt_g <= bus.cal_g_gain;
        r_tgt_b <= bus.cal_b_gain;
      end
      if (w_commit) begin
        r_gain_r <= w_new_r;
        r_gain_g <= w_new_g;
        r_gain_b <= w_new_b;
      end
      r_cal_sel <= w_mode_chg;
      if (w_mode_chg) r_cal_direct <= ~bus.cfg_mode[1];
      r_gain_update <= w_commit && w_changed;
      r_busy        <= (w_state_nxt != S_IDLE);
      if (w_mode_chg || w_done_clr) r_done <= 1'b0;
      else if (w_done_set)          r_done <= 1'b1;
      if (w_mode_chg)     r_tmo_err <= 1'b0;
      else if (w_tmo_set) r_tmo_err <= 1'b1;
    end
  end

  assign bus.cal_sel     = r_cal_sel;
  assign bus.cal_direct  = r_cal_direct;
  assign bus.r_gain_out  = r_gain_r;
  assign bus.g_gain_out  = r_gain_g;
  assign bus.b_gain_out  = r_gain_b;
  assign bus.gain_update = r_gain_update;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.tmo_err     = r_tmo_err;

endmodule

// File: tb/tb_awb_gain_sched.sv
// Purpose: self-checking bench for awb_gain_sched: a table of manual/bypass frame
//   vectors with hand-computed gains, then directed auto-continuous, timeout, one-shot,
//   simultaneous cal_valid/frame_end with near-full-scale gain, and mid-frame reset.
module tb_awb_gain_sched;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  awb_gain_sched_if #(.GAIN_W(8)) bus ();

  awb_gain_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] cr, cg, cb;
    logic [7:0] er, eg, eb;
    logic       eupd, esel, edir, ebusy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_gains(input string name, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
    chk({name, "_r"}, 32'(bus.r_gain_out), 32'(r));
    chk({name, "_g"}, 32'(bus.g_gain_out), 32'(g));
    chk({name, "_b"}, 32'(bus.b_gain_out), 32'(b));
  endtask

  // One-cycle frame_end and/or cal_valid pulse; returns 1ns after the edge that took it.
  task automatic pulse(input logic fe, input logic cv);
    @(posedge clk); #1;
    bus.frame_end = fe;
    bus.cal_valid = cv;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
    bus.cal_valid = 1'b0;
  endtask

  task automatic set_cal(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.cal_r_gain = r;
    bus.cal_g_gain = g;
    bus.cal_b_gain = b;
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //          mode   cr   cg   cb   er   eg   eb  upd  sel  dir busy
    vecs[0]  = '{2'b01, 160, 100, 128, 128, 128, 128, 0, 1, 1, 0};
    vecs[1]  = '{2'b01, 160, 100, 128, 136, 120, 128, 1, 0, 1, 0};
    vecs[2]  = '{2'b01, 160, 100, 128, 144, 112, 128, 1, 0, 1, 0};
    vecs[3]  = '{2'b01, 160, 100, 128, 152, 104, 128, 1, 0, 1, 0};
    vecs[4]  = '{2'b01, 160, 100, 128, 160, 100, 128, 1, 0, 1, 0};
    vecs[5]  = '{2'b01, 160, 100, 128, 160, 100, 128, 0, 0, 1, 0};
    vecs[6]  = '{2'b00,   0,   0,   0, 160, 100, 128, 0, 1, 1, 0};
    vecs[7]  = '{2'b00,   0,   0,   0, 152, 108, 128, 1, 0, 1, 0};
    vecs[8]  = '{2'b00,   0,   0,   0, 144, 116, 128, 1, 0, 1, 0};
    vecs[9]  = '{2'b00,   0,   0,   0, 136, 124, 128, 1, 0, 1, 0};
    vecs[10] = '{2'b00,   0,   0,   0, 128, 128, 128, 1, 0, 1, 0};
    vecs[11] = '{2'b00,   0,   0,   0, 128, 128, 128, 0, 0, 1, 0};

    bus.cfg_mode   = 2'b00;
    bus.cfg_start  = 1'b0;
    bus.cfg_r_gain = 8'd0;
    bus.cfg_g_gain = 8'd0;
    bus.cfg_b_gain = 8'd0;
    bus.frame_end  = 1'b0;
    bus.cal_valid  = 1'b0;
    set_cal(8'd0, 8'd0, 8'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_gains("rst0", 8'd128, 8'd128, 8'd128);
    chk("rst0_dir",  32'(bus.cal_direct),  32'd1);
    chk("rst0_sel",  32'(bus.cal_sel),     32'd0);
    chk("rst0_busy", 32'(bus.busy),        32'd0);
    chk("rst0_upd",  32'(bus.gain_update), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual ramp toward 160/100/128 then back to unity in bypass
    for (int i = 0; i < 12; i++) begin
      bus.cfg_mode   = vecs[i].mode;
      bus.cfg_r_gain = vecs[i].cr;
      bus.cfg_g_gain = vecs[i].cg;
      bus.cfg_b_gain = vecs[i].cb;
      pulse(1'b1, 1'b0);
      chk_gains($sformatf("v%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
      chk($sformatf("v%0d_upd", i),  32'(bus.gain_update), 32'(vecs[i].eupd));
      chk($sformatf("v%0d_sel", i),  32'(bus.cal_sel),     32'(vecs[i].esel));
      chk($sformatf("v%0d_dir", i),  32'(bus.cal_direct),  32'(vecs[i].edir));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy),        32'(vecs[i].ebusy));
    end

    // Auto-continuous: mode change, IDLE->SKIP, two skip frames, then MEAS
    bus.cfg_mode = 2'b10;
    pulse(1'b1, 1'b0);
    chk("t3_sel",  32'(bus.cal_sel),    32'd1);
    chk("t3_dir",  32'(bus.cal_direct), 32'd0);
    chk("t3_busy0", 32'(bus.busy),      32'd0);
    pulse(1'b1, 1'b0);
    chk("t3_busy1", 32'(bus.busy), 32'd1);
    set_cal(8'd0, 8'd0, 8'd0);
    pulse(1'b0, 1'b1);                   // in SKIP: ignored
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);                   // now MEAS
    set_cal(8'd120, 8'd128, 8'd140);
    pulse(1'b0, 1'b1);
    chk_gains("t3_pre", 8'd128, 8'd128, 8'd128);
    pulse(1'b1, 1'b0);
    chk_gains("t3_commit", 8'd120, 8'd128, 8'd136);
    chk("t3_upd",   32'(bus.gain_update), 32'd1);
    chk("t3_busy2", 32'(bus.busy),        32'd1);
    set_cal(8'd0, 8'd0, 8'd0);
    pulse(1'b0, 1'b1);                   // back in SKIP: ignored
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);                   // now MEAS
    chk_gains("t3_skip", 8'd120, 8'd128, 8'd136);

    // Timeout: three frames in MEAS without a result
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("t5_tmo_early", 32'(bus.tmo_err), 32'd0);
    pulse(1'b1, 1'b0);
    chk("t5_tmo", 32'(bus.tmo_err), 32'd1);
    chk_gains("t5", 8'd120, 8'd128, 8'd136);
    chk("t5_busy", 32'(bus.busy), 32'd1);
    pulse(1'b0, 1'b1);                   // in SKIP after timeout: ignored
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);                   // now MEAS
    chk_gains("t5_skip", 8'd120, 8'd128, 8'd136);
    set_cal(8'd128, 8'd128, 8'd128);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    chk_gains("t5_recover", 8'd128, 8'd128, 8'd128);

    // One-shot
    bus.cfg_mode = 2'b11;
    pulse(1'b1, 1'b0);
    chk("t4_tmo_clr", 32'(bus.tmo_err), 32'd0);
    chk("t4_busy0",   32'(bus.busy),    32'd0);
    pulse(1'b1, 1'b0);                   // not armed: stays IDLE
    chk("t4_idle", 32'(bus.busy), 32'd0);
    start_pulse();
    pulse(1'b1, 1'b0);                   // SKIP
    chk("t4_busy1", 32'(bus.busy), 32'd1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);                   // MEAS
    set_cal(8'd132, 8'd128, 8'd126);
    pulse(1'b0, 1'b1);
    chk("t4_done_pre", 32'(bus.done), 32'd0);
    pulse(1'b1, 1'b0);
    chk_gains("t4", 8'd132, 8'd128, 8'd126);
    chk("t4_done", 32'(bus.done),        32'd1);
    chk("t4_busy2", 32'(bus.busy),       32'd0);
    chk("t4_upd",  32'(bus.gain_update), 32'd1);
    set_cal(8'd0, 8'd0, 8'd0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk_gains("t4_hold", 8'd132, 8'd128, 8'd126);
    chk("t4_done_hold", 32'(bus.done), 32'd1);

    // Edge: ramp red to 250 in manual, then same-cycle cal_valid/frame_end in MEAS
    bus.cfg_mode   = 2'b01;
    bus.cfg_r_gain = 8'd250;
    bus.cfg_g_gain = 8'd128;
    bus.cfg_b_gain = 8'd128;
    pulse(1'b1, 1'b0);
    chk("t6_done_clr", 32'(bus.done), 32'd0);
    for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0);
    chk_gains("t6_ramp", 8'd250, 8'd128, 8'd128);
    bus.cfg_mode = 2'b10;
    pulse(1'b1, 1'b0);                   // mode change
    pulse(1'b1, 1'b0);                   // SKIP
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);                   // MEAS
    pulse(1'b1, 1'b0);                   // tmo 1
    pulse(1'b1, 1'b0);                   // tmo 2
    set_cal(8'd255, 8'd128, 8'd128);
    pulse(1'b1, 1'b1);                   // result wins over third timeout frame
    chk("t6_no_tmo", 32'(bus.tmo_err), 32'd0);
    chk_gains("t6_pre", 8'd250, 8'd128, 8'd128);
    pulse(1'b1, 1'b0);
    chk_gains("t6_sat", 8'd255, 8'd128, 8'd128);
    chk("t6_upd", 32'(bus.gain_update), 32'd1);
    chk("t6_tmo", 32'(bus.tmo_err),     32'd0);

    // Mid-frame reset while busy
    bus.cfg_mode = 2'b00;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_gains("t1", 8'd128, 8'd128, 8'd128);
    chk("t1_dir",  32'(bus.cal_direct), 32'd1);
    chk("t1_busy", 32'(bus.busy),       32'd0);
    chk("t1_done", 32'(bus.done),       32'd0);
    chk("t1_tmo",  32'(bus.tmo_err),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pulse(1'b1, 1'b0);
      chk($sformatf("t1_upd%0d", i), 32'(bus.gain_update), 32'd0);
      chk_gains($sformatf("t1_f%0d", i), 8'd128, 8'd128, 8'd128);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
